mem_wb_commit: RTL and testbench

Write-back commit unit that drives the register-file write port (`wena`/`wrd`/`wdata`) and the pipeline stall line `memhazard`. It accepts one retiring instruction per cycle from the memory stage: an ALU result, or a load whose data comes from the data cache with variable latency. It formats load data, which means byte/half selection plus sign or zero extension. While a load miss is outstanding it holds `memhazard` high so that upstream stages and the register-file read ports freeze.

---
 rtl/mem_wb_commit.sv | 179 +++++++++++++++++
 tb/tb_mem_wb_commit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_commit.sv
// Write-back commit unit: retires one instruction per cycle into the register
// file, formats load data, and stalls the pipeline while a load miss is pending.
module mem_wb_commit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_wb_en,
  input  logic        in_is_load,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_res,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_rdata,
  output logic        wena,
  output logic [4:0]  wrd,
  output logic [31:0] wdata,
  output logic        memhazard,
  output logic        err,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wena_q, wena_d;
  logic [4:0]  wrd_q, wrd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        memhazard_q, memhazard_d;
  logic        err_q, err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Commit request gathered from whichever path retires this cycle.
  logic        wr_req;
  logic [4:0]  wr_rd;
  logic [31:0] wr_val;

  // Byte/half selection plus extension of the aligned cache word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = d;
    endcase
  endfunction

  function automatic logic bad_funct3(input logic [2:0] f3);
    bad_funct3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                   f3 == 3'b100 || f3 == 3'b101);
  endfunction

  // Next-state, write-port and flag computation.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    memhazard_d = memhazard_q;
    err_d       = err_q;
    wr_req      = 1'b0;
    wr_rd       = 5'd0;
    wr_val      = 32'd0;
    wena_d      = 1'b0;
    wrd_d       = 5'd0;
    wdata_d     = 32'd0;
    stall_cnt_d = (memhazard_q && stall_cnt_q != 32'hFFFF_FFFF) ?
                  stall_cnt_q + 32'd1 : stall_cnt_q;

    case (state_q)
      IDLE: begin
        memhazard_d = 1'b0;
        cnt_d       = 8'd0;
        if (in_valid) begin
          if (!in_is_load) begin
            wr_req = 1'b1;
            wr_rd  = in_wb_en ? in_rd : 5'd0;
            wr_val = in_alu_res;
          end else if (dc_resp_valid) begin
            wr_req = 1'b1;
            wr_rd  = in_wb_en ? in_rd : 5'd0;
            wr_val = fmt_load(in_funct3, in_addr_lo, dc_rdata);
            if (bad_funct3(in_funct3)) err_d = 1'b1;
          end else begin
            // A suppressed destination is captured as rd=0 so the eventual
            // response still clears the stall but never writes.
            rd_d        = in_wb_en ? in_rd : 5'd0;
            funct3_d    = in_funct3;
            addr_lo_d   = in_addr_lo;
            state_d     = WAIT;
            memhazard_d = 1'b1;
          end
        end else if (dc_resp_valid) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (dc_resp_valid) begin
          wr_req      = 1'b1;
          wr_rd       = rd_q;
          wr_val      = fmt_load(funct3_q, addr_lo_q, dc_rdata);
          if (bad_funct3(funct3_q)) err_d = 1'b1;
          state_d     = IDLE;
          memhazard_d = 1'b0;
          cnt_d       = 8'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d     = IDLE;
          memhazard_d = 1'b0;
          err_d       = 1'b1;
          cnt_d       = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // wrd/wdata stay zero unless a real write happens, so an idle port never
    // aliases a live register through the forwarding path.
    if (wr_req && wr_rd != 5'd0) begin
      wena_d  = 1'b1;
      wrd_d   = wr_rd;
      wdata_d = wr_val;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      cnt_q       <= 8'd0;
      wena_q      <= 1'b0;
      wrd_q       <= 5'd0;
      wdata_q     <= 32'd0;
      memhazard_q <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      wena_q      <= wena_d;
      wrd_q       <= wrd_d;
      wdata_q     <= wdata_d;
      memhazard_q <= memhazard_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wena      = wena_q;
  assign wrd       = wrd_q;
  assign wdata     = wdata_q;
  assign memhazard = memhazard_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_commit.sv
// Directed bench for mem_wb_commit: single-cycle vector table plus
// hand-written miss, timeout and reset sequences.
module tb_mem_wb_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_wb_en, in_is_load;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_res;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dc_resp_valid;
  logic [31:0] dc_rdata;
  logic        wena;
  logic [4:0]  wrd;
  logic [31:0] wdata;
  logic        memhazard, err;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  mem_wb_commit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_wb_en(in_wb_en), .in_is_load(in_is_load),
    .in_rd(in_rd), .in_alu_res(in_alu_res), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
    .wena(wena), .wrd(wrd), .wdata(wdata), .memhazard(memhazard),
    .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, wb_en, is_load;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        resp;
    logic [31:0] rdata;
    logic        e_wena;
    logic [4:0]  e_wrd;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] f3, input logic [1:0] lo,
                       input logic rv, input logic [31:0] rdat);
    in_valid = v; in_wb_en = we; in_is_load = ld; in_rd = rd; in_alu_res = alu;
    in_funct3 = f3; in_addr_lo = lo; dc_resp_valid = rv; dc_rdata = rdat;
  endtask

  initial begin
    int hi_cnt;
    //           valid we ld rd  alu           f3    lo  resp rdata         wena wrd wdata
    vecs[0]  = '{1, 1, 0, 5,  32'h1234_5678, 3'b000, 0, 0, 32'h0,         1, 5,  32'h1234_5678};
    vecs[1]  = '{0, 0, 0, 0,  32'h0,         3'b000, 0, 0, 32'h0,         0, 0,  32'h0};
    vecs[2]  = '{1, 1, 1, 7,  32'h0,         3'b000, 2, 1, 32'h00A1_0000, 1, 7,  32'hFFFF_FFA1};
    vecs[3]  = '{1, 1, 1, 7,  32'h0,         3'b100, 2, 1, 32'h00A1_0000, 1, 7,  32'h0000_00A1};
    vecs[4]  = '{1, 1, 1, 8,  32'h0,         3'b001, 0, 1, 32'h1234_8765, 1, 8,  32'hFFFF_8765};
    vecs[5]  = '{1, 1, 1, 8,  32'h0,         3'b101, 2, 1, 32'h8001_0000, 1, 8,  32'h0000_8001};
    vecs[6]  = '{1, 1, 1, 9,  32'h0,         3'b010, 0, 1, 32'hDEAD_BEEF, 1, 9,  32'hDEAD_BEEF};
    vecs[7]  = '{1, 1, 1, 2,  32'h0,         3'b000, 3, 1, 32'h7F00_0000, 1, 2,  32'h0000_007F};
    vecs[8]  = '{1, 1, 1, 3,  32'h0,         3'b100, 0, 1, 32'h0000_00FF, 1, 3,  32'h0000_00FF};
    vecs[9]  = '{1, 1, 0, 0,  32'hAAAA_5555, 3'b000, 0, 0, 32'h0,         0, 0,  32'h0};
    vecs[10] = '{1, 0, 0, 9,  32'h5555_AAAA, 3'b000, 0, 0, 32'h0,         0, 0,  32'h0};
    vecs[11] = '{1, 1, 0, 31, 32'hFFFF_FFFF, 3'b000, 0, 0, 32'h0,         1, 31, 32'hFFFF_FFFF};
    vecs[12] = '{1, 0, 1, 3,  32'h0,         3'b010, 0, 1, 32'h1111_2222, 0, 0,  32'h0};
    vecs[13] = '{0, 1, 0, 6,  32'h9999_9999, 3'b000, 0, 0, 32'h0,         0, 0,  32'h0};

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #22;
    chk("rst_wena", 32'(wena), 32'd0);
    chk("rst_wrd", 32'(wrd), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_memhazard", 32'(memhazard), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-cycle table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].wb_en, vecs[i].is_load, vecs[i].rd, vecs[i].alu,
            vecs[i].f3, vecs[i].lo, vecs[i].resp, vecs[i].rdata);
      tick();
      $display("vec %0d: wena=%0b wrd=%0d wdata=%h mh=%0b", i, wena, wrd, wdata, memhazard);
      chk($sformatf("vec%0d_wena", i), 32'(wena), 32'(vecs[i].e_wena));
      chk($sformatf("vec%0d_wrd", i), 32'(wrd), 32'(vecs[i].e_wrd));
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d_mh", i), 32'(memhazard), 32'd0);
    end
    chk("table_err", 32'(err), 32'd0);

    // LH miss, response in the third stall cycle
    drive(1, 1, 1, 10, 0, 3'b001, 2, 0, 0);
    tick();
    chk("miss_mh1", 32'(memhazard), 32'd1);
    chk("miss_wena1", 32'(wena), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("miss_mh", 32'(memhazard), 32'd1);
    end
    dc_resp_valid = 1'b1; dc_rdata = 32'h8001_0000;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("miss LH: wena=%0b wrd=%0d wdata=%h mh=%0b stall=%0d", wena, wrd, wdata, memhazard, stall_cnt);
    chk("miss_wena", 32'(wena), 32'd1);
    chk("miss_wrd", 32'(wrd), 32'd10);
    chk("miss_wdata", wdata, 32'hFFFF_8001);
    chk("miss_mh_drop", 32'(memhazard), 32'd0);
    chk("miss_stall_cnt", stall_cnt, 32'd3);
    tick();
    chk("miss_after_wena", 32'(wena), 32'd0);
    chk("miss_err", 32'(err), 32'd0);

    // Load miss to rd=0: stalls, never writes
    drive(1, 1, 1, 0, 0, 3'b010, 0, 0, 0);
    tick();
    chk("rd0_mh", 32'(memhazard), 32'd1);
    dc_resp_valid = 1'b1; dc_rdata = 32'hCAFE_0001;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("miss rd0: wena=%0b wrd=%0d mh=%0b stall=%0d", wena, wrd, memhazard, stall_cnt);
    chk("rd0_wena", 32'(wena), 32'd0);
    chk("rd0_wrd", 32'(wrd), 32'd0);
    chk("rd0_mh_drop", 32'(memhazard), 32'd0);
    chk("rd0_stall_cnt", stall_cnt, 32'd4);

    // Timeout: no response ever arrives
    drive(1, 1, 1, 12, 0, 3'b010, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hi_cnt = memhazard ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (memhazard) hi_cnt++;
      if (wena) chk("to_no_write", 32'(wena), 32'd0);
    end
    $display("timeout: hazard_cycles=%0d err=%0b stall=%0d", hi_cnt, err, stall_cnt);
    chk("to_hazard_cycles", 32'(hi_cnt), 32'd8);
    chk("to_err", 32'(err), 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'd12);
    drive(1, 1, 0, 4, 32'hCAFE_F00D, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_alu_wena", 32'(wena), 32'd1);
    chk("to_alu_wrd", 32'(wrd), 32'd4);
    chk("to_alu_wdata", wdata, 32'hCAFE_F00D);

    // Asynchronous reset mid-WAIT, then a late response
    drive(1, 1, 1, 14, 0, 3'b010, 0, 0, 0);
    tick();
    tick();
    chk("ar_mh_before", 32'(memhazard), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: wena=%0b mh=%0b err=%0b", wena, memhazard, err);
    chk("ar_mh", 32'(memhazard), 32'd0);
    chk("ar_wena", 32'(wena), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("late resp: wena=%0b wrd=%0d err=%0b", wena, wrd, err);
    chk("late_wena", 32'(wena), 32'd0);
    chk("late_wrd", 32'(wrd), 32'd0);
    chk("late_err", 32'(err), 32'd1);

    // Undefined funct3 on a hit: full word written and err raised
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    drive(1, 1, 1, 6, 0, 3'b011, 1, 1, 32'h1122_3344);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("bad funct3: wena=%0b wdata=%h err=%0b", wena, wdata, err);
    chk("bf3_wena", 32'(wena), 32'd1);
    chk("bf3_wdata", wdata, 32'h1122_3344);
    chk("bf3_err", 32'(err), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
